// File: rtl/div_radix2.sv
// Radix-2 restoring integer divider (DIV/DIVU), 32 cycles per quotient, result = {HI=remainder, LO=quotient}.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor completes in one cycle instead of the full iteration.
module div_radix2 (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    input  logic        cancel_i,
    output logic        stall_o,
    output logic        ready_o,
    output logic [63:0] result_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] div_q, div_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dzero_q, dzero_d;
    logic [63:0] result_q, result_d;

    logic        opb_zero_s;
    logic        fast_zero_s;
    logic [33:0] rem_shift_s;
    logic [33:0] diff_s;
    logic [32:0] rem_step_s;
    logic [31:0] quo_step_s;
    logic [31:0] lo_fin_s;
    logic [31:0] hi_fin_s;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
        return (en && v[31]) ? neg32(v) : v;
    endfunction

    // Zero-divisor detection and selection of the single-cycle shortcut
    always_comb begin
        opb_zero_s = (opb_i == 32'h0000_0000);
`ifdef DIV_ZERO_FAST_EN
        fast_zero_s = opb_zero_s;
`else
        fast_zero_s = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a flush always wins
    always_comb begin
        state_d = state_q;
        if (cancel_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = fast_zero_s ? ST_DONE : ST_CALC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (count_q == 5'd31) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        stall_o = 1'b0;
        ready_o = 1'b0;
        case (state_q)
            ST_IDLE: stall_o = start_i & ~cancel_i;
            ST_CALC: stall_o = ~cancel_i;
            ST_DONE: ready_o = 1'b1;
            default: begin
                stall_o = 1'b0;
                ready_o = 1'b0;
            end
        endcase
    end

    // One restoring iteration: shift in next dividend bit, trial-subtract the divisor
    always_comb begin
        rem_shift_s = {rem_q, quo_q[31]};
        diff_s      = rem_shift_s - {2'b00, div_q};
        if (diff_s[33]) begin
            rem_step_s = rem_shift_s[32:0];
            quo_step_s = {quo_q[30:0], 1'b0};
        end else begin
            rem_step_s = diff_s[32:0];
            quo_step_s = {quo_q[30:0], 1'b1};
        end
    end

    // Sign fix-up of the final iteration; with a zero divisor the remainder
    // naturally equals |dividend|, so restoring its sign returns opa unchanged
    always_comb begin
        hi_fin_s = neg_rem_q ? neg32(rem_step_s[31:0]) : rem_step_s[31:0];
        if (dzero_q) begin
            lo_fin_s = 32'hFFFF_FFFF;
        end else begin
            lo_fin_s = neg_quo_q ? neg32(quo_step_s) : quo_step_s;
        end
    end

    // Datapath next-state
    always_comb begin
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dzero_d   = dzero_q;
        result_d  = result_q;
        if (!cancel_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        count_d   = 5'd0;
                        rem_d     = 33'd0;
                        quo_d     = abs32(opa_i, signed_i);
                        div_d     = abs32(opb_i, signed_i);
                        neg_quo_d = signed_i & (opa_i[31] ^ opb_i[31]);
                        neg_rem_d = signed_i & opa_i[31];
                        dzero_d   = opb_zero_s;
                        if (fast_zero_s) begin
                            result_d = {opa_i, 32'hFFFF_FFFF};
                        end else begin
                            result_d = result_q;
                        end
                    end else begin
                        count_d = count_q;
                    end
                end
                ST_CALC: begin
                    rem_d   = rem_step_s;
                    quo_d   = quo_step_s;
                    count_d = count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        result_d = {hi_fin_s, lo_fin_s};
                    end else begin
                        result_d = result_q;
                    end
                end
                ST_DONE: count_d = count_q;
                default: count_d = count_q;
            endcase
        end else begin
            result_d = result_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q   <= 5'd0;
            rem_q     <= 33'd0;
            quo_q     <= 32'd0;
            div_q     <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dzero_q   <= 1'b0;
            result_q  <= 64'd0;
        end else begin
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dzero_q   <= dzero_d;
            result_q  <= result_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: doc/div_radix2.md
DIV_RADIX2 -- requirements
Module: div_radix2

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port start_i, input, 1: divide request from the decode-stage DIV/DIVU control; held high while stall_o is high.
REQ-004 SHALL have port signed_i, input, 1: 1 = DIV (two's complement), 0 = DIVU; sampled with start_i.
REQ-005 SHALL have ports opa_i and opb_i, input, 32 each: dividend and divisor; sampled with start_i.
REQ-006 SHALL have port cancel_i, input, 1: pipeline flush (exception/ERET); aborts any operation.
REQ-007 SHALL have port stall_o, output, 1: pipeline stall request while a division is pending.
REQ-008 SHALL have port ready_o, output, 1: one-cycle pulse, result_o valid for HI/LO write.
REQ-009 SHALL have port result_o, output, 64: {HI = remainder, LO = quotient}.

Function
REQ-010 SHALL implement FSM with states IDLE, CALC and DONE.
REQ-011 IDLE: start_i=1 and cancel_i=0 SHALL latch |opa_i|, |opb_i|, the operand signs and signed_i, clear the iteration count, and go to CALC; otherwise stay in IDLE.
REQ-012 CALC SHALL be radix-2 restoring: one quotient bit per cycle, MSB first, over a 33-bit partial remainder; exactly 32 cycles (count 0..31), then go to DONE.
REQ-013 DONE SHALL assert ready_o, drive the registered result on result_o, and return unconditionally to IDLE.
REQ-014 DONE SHALL NOT start a new operation even if start_i is still high.
REQ-015 stall_o SHALL be combinational: (IDLE & start_i) | CALC, gated by ~cancel_i; stall_o SHALL be 0 in DONE.
REQ-016 Latency: start_i accepted in cycle N -> ready_o in cycle N+33; stall_o high for cycles N..N+32.
REQ-017 Signed: quotient SHALL be negated when the dividend and divisor signs differ; remainder SHALL take the dividend sign; all arithmetic SHALL be modulo 2^32.
REQ-018 0x80000000 / 0xFFFFFFFF (signed) SHALL give LO=0x80000000 and HI=0x00000000, with no exception.
REQ-019 Divisor zero (either signedness) SHALL give HI=opa_i unchanged and LO=0xFFFFFFFF.
REQ-020 result_o SHALL be loaded only on entry to DONE; it SHALL hold its value otherwise.
REQ-021 cancel_i=1 in any state SHALL force IDLE on the next edge; no ready_o SHALL be asserted and result_o SHALL be unchanged.
REQ-022 cancel_i=1 together with start_i=1 in IDLE SHALL NOT start an operation.
REQ-023 Back-to-back divides SHALL be supported: a start_i in the IDLE cycle after DONE begins a new operation.

Reset
REQ-024 resetn=0 SHALL immediately force IDLE, count=0, result_o=64'h0 and ready_o=0; stall_o SHALL then follow REQ-015.
REQ-025 Reset asserted during CALC SHALL discard the operation; no ready_o SHALL be asserted after reset is released.

Configuration
REQ-026 Macro DIV_ZERO_FAST_EN SHALL control the divide-by-zero path.
REQ-027 With DIV_ZERO_FAST_EN defined: start_i with opb_i=0 accepted in IDLE SHALL go directly to DONE. Latency is 1 cycle, stall_o is high for one cycle only, and the REQ-019 result applies.
REQ-028 Without DIV_ZERO_FAST_EN: divide-by-zero SHALL take the full REQ-016 latency, and the REQ-019 result SHALL be forced in DONE.

Verification
REQ-029 DIVU 0x00000064 / 0x00000007 -> ready_o at N+33, HI=0x00000002, LO=0x0000000E; stall_o high for exactly 33 cycles.
REQ-030 DIV 0xFFFFFFF9 (-7) / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0x00000000.
REQ-031 DIV 0x12345678 / 0 -> HI=0x12345678, LO=0xFFFFFFFF. ready_o at N+1 with DIV_ZERO_FAST_EN; at N+33 without.
REQ-032 DIVU 100/7 with cancel_i pulsed at N+10 -> stall_o=0 in that cycle, FSM in IDLE at N+11, no ready_o, result_o keeps its prior value.
REQ-033 Two back-to-back DIVU (100/7, then 0xFFFFFFFF/0x10) -> second ready_o at N+67; second result HI=0x0000000F, LO=0x0FFFFFFF.
REQ-034 resetn pulsed low at N+5 during CALC -> result_o=0 immediately, ready_o never asserted, IDLE on release.
